lut_config_writer: RTL and testbench



---
 rtl/lut_config_writer_if.sv | 17 +
 rtl/lut_config_writer.sv | 117 +++++++++++
 tb/tb_lut_config_writer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_config_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : lut_config_writer_if
// Brief    : Valid/ready stream carrying configuration words into the writer.
// Revision : 1.0 - initial release
// ============================================================================
interface lut_config_writer_if #(
    parameter int WORD_WIDTH = 32
);
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/lut_config_writer.sv
`default_nettype none
// ============================================================================
// Module   : lut_config_writer
// Brief    : Serialises config words into a LUTRAM bank, one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef ZUMA_LUT_SIZE
`define ZUMA_LUT_SIZE 6
`endif

module lut_config_writer #(
    parameter int ZUMA_LUT_SIZE = `ZUMA_LUT_SIZE,
    parameter int NUM_LUTS      = 8,
    parameter int WORD_WIDTH    = 32
) (
    input  wire                      clk,
    input  wire                      reset,
    input  wire                      start,
    input  wire                      abort,
    lut_config_writer_if.slave       in_if,
    output logic [ZUMA_LUT_SIZE-1:0] cfg_addr,
    output logic                     cfg_d,
    output logic [NUM_LUTS-1:0]      cfg_we,
    output logic                     busy,
    output logic                     done
);
    localparam int c_LUT_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam int c_BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [c_LUT_W-1:0]       c_LAST_LUT  = c_LUT_W'(NUM_LUTS - 1);
    localparam logic [ZUMA_LUT_SIZE-1:0] c_LAST_ADDR = '1;
    localparam logic [c_BIT_W-1:0]       c_LAST_BIT  = c_BIT_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   r_state,   w_state_nxt;
    logic [c_LUT_W-1:0]       r_lut_idx, w_lut_idx_nxt;
    logic [ZUMA_LUT_SIZE-1:0] r_addr,    w_addr_nxt;
    logic [c_BIT_W-1:0]       r_bit_idx, w_bit_idx_nxt;
    logic [WORD_WIDTH-1:0]    r_shreg,   w_shreg_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_lut_idx <= '0;
            r_addr    <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lut_idx <= w_lut_idx_nxt;
            r_addr    <= w_addr_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shreg   <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_lut_idx_nxt = r_lut_idx;
        w_addr_nxt    = r_addr;
        w_bit_idx_nxt = r_bit_idx;
        w_shreg_nxt   = r_shreg;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt   = S_LOAD;
                    w_lut_idx_nxt = '0;
                    w_addr_nxt    = '0;
                    w_bit_idx_nxt = '0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (in_if.in_valid) begin
                    w_shreg_nxt   = in_if.in_data;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_shreg_nxt   = r_shreg >> 1;
                    w_bit_idx_nxt = r_bit_idx + c_BIT_W'(1);
                    w_addr_nxt    = r_addr + ZUMA_LUT_SIZE'(1);
                    if (r_addr == c_LAST_ADDR) begin
                        w_lut_idx_nxt = r_lut_idx + c_LUT_W'(1);
                    end
                    // The end of the bank wins over the end of a word, so
                    // unused high bits of the last word are simply dropped.
                    if (r_addr == c_LAST_ADDR && r_lut_idx == c_LAST_LUT) begin
                        w_state_nxt = S_DONE;
                    end else if (r_bit_idx == c_LAST_BIT) begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign in_if.in_ready = (r_state == S_LOAD);
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign cfg_addr       = r_addr;
    assign cfg_d          = (r_state == S_WRITE) & r_shreg[0];
    assign cfg_we         = (r_state == S_WRITE) ? (NUM_LUTS'(1) << r_lut_idx) : '0;
endmodule
`default_nettype wire

// File: tb/tb_lut_config_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_config_writer
// Brief    : Randomised scoreboard bench for a small bank and the default bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_config_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_s = 1'b0, abort_s = 1'b0, start_d = 1'b0, abort_d = 1'b0;
    logic [1:0] addr_s;
    logic       d_s, busy_s, done_s;
    logic [2:0] we_s;
    logic [5:0] addr_d;
    logic       d_d, busy_d, done_d;
    logic [7:0] we_d;

    lut_config_writer_if #(.WORD_WIDTH(8))  if_s ();
    lut_config_writer_if #(.WORD_WIDTH(32)) if_d ();

    lut_config_writer #(.ZUMA_LUT_SIZE(2), .NUM_LUTS(3), .WORD_WIDTH(8)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort_s), .in_if(if_s),
        .cfg_addr(addr_s), .cfg_d(d_s), .cfg_we(we_s), .busy(busy_s), .done(done_s));

    lut_config_writer #(.ZUMA_LUT_SIZE(6), .NUM_LUTS(8), .WORD_WIDTH(32)) dut_d (
        .clk(clk), .reset(reset), .start(start_d), .abort(abort_d), .in_if(if_d),
        .cfg_addr(addr_d), .cfg_d(d_d), .cfg_we(we_d), .busy(busy_d), .done(done_d));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int exp_q_s[$], exp_q_d[$];
    int pos_s = 0, pos_d = 0;
    logic [3:0]  exp_mem_s [3], mem_s [3];
    logic [63:0] exp_mem_d [8], mem_d [8];
    int n_wr_s = 0, n_done_s = 0, n_hs_s = 0;
    int n_wr_d = 0, n_done_d = 0, n_hs_d = 0;
    int e_s, l_s, e_d, l_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic int onehot_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Reference model: the bank is one contiguous bitstream, bit p lands in
    // LUT p / 2^K at address p % 2^K.
    task automatic push_s(input logic [7:0] w);
        for (int j = 0; j < 8; j++) begin
            if (pos_s < 12) begin
                exp_q_s.push_back((pos_s / 4) * 1024 + (pos_s % 4) * 2 + int'(w[j]));
                exp_mem_s[pos_s / 4][pos_s % 4] = w[j];
                pos_s++;
            end
        end
    endtask

    task automatic push_d(input logic [31:0] w);
        for (int j = 0; j < 32; j++) begin
            if (pos_d < 512) begin
                exp_q_d.push_back((pos_d / 64) * 1024 + (pos_d % 64) * 2 + int'(w[j]));
                exp_mem_d[pos_d / 64][pos_d % 64] = w[j];
                pos_d++;
            end
        end
    endtask

    always @(negedge clk) begin : mon_s
        if (!reset) begin
            if (if_s.in_valid && if_s.in_ready && !abort_s) n_hs_s++;
            if (we_s != 3'b0) begin
                check("s_onehot", 64'($onehot(we_s)), 64'd1);
                l_s = onehot_idx({5'b0, we_s});
                n_wr_s++;
                if (exp_q_s.size() == 0) fail_now("s_unexpected_write");
                else begin
                    e_s = exp_q_s.pop_front();
                    check("s_write", 64'(l_s * 1024 + int'(addr_s) * 2 + int'(d_s)), 64'(e_s));
                end
                mem_s[l_s][addr_s] = d_s;
            end
            if (done_s) n_done_s++;
        end
    end

    always @(negedge clk) begin : mon_d
        if (!reset) begin
            if (if_d.in_valid && if_d.in_ready && !abort_d) n_hs_d++;
            if (we_d != 8'b0) begin
                check("d_onehot", 64'($onehot(we_d)), 64'd1);
                l_d = onehot_idx(we_d);
                n_wr_d++;
                if (exp_q_d.size() == 0) fail_now("d_unexpected_write");
                else begin
                    e_d = exp_q_d.pop_front();
                    check("d_write", 64'(l_d * 1024 + int'(addr_d) * 2 + int'(d_d)), 64'(e_d));
                end
                mem_d[l_d][addr_d] = d_d;
            end
            if (done_d) n_done_d++;
        end
    end

    task automatic wait_ready_s(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (if_s.in_ready) ok = 1'b1;
        end
        if (!ok) fail_now("s_ready_timeout");
    endtask

    task automatic start_pulse_s();
        @(posedge clk); #1;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        check("s_start_latency", 64'(if_s.in_ready), 64'd1);
    endtask

    task automatic feed_s(input logic [7:0] w, input int stall);
        bit ok;
        if (stall == 0) begin
            if_s.in_data  = w;
            if_s.in_valid = 1'b1;
        end else begin
            if_s.in_valid = 1'b0;
        end
        wait_ready_s(ok);
        if (!ok) return;
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                if (i > 0) @(negedge clk);
                check("s_stall_ready", 64'(if_s.in_ready), 64'd1);
                check("s_stall_we", 64'(we_s), 64'd0);
            end
            @(posedge clk); #1;
            if_s.in_data  = w;
            if_s.in_valid = 1'b1;
        end
        push_s(w);
        @(posedge clk); #1;
        check("s_first_write", 64'(we_s != 3'b0), 64'd1);
    endtask

    task automatic run_pass_s(input logic [7:0] w0, input logic [7:0] w1,
                              input int stall, input bit start_mid);
        int d0, h0, r0;
        pos_s = 0;
        exp_q_s.delete();
        d0 = n_done_s; h0 = n_hs_s; r0 = n_wr_s;
        start_pulse_s();
        feed_s(w0, stall);
        if (start_mid) begin
            start_s = 1'b1;
            @(posedge clk); #1;
            start_s = 1'b0;
        end
        feed_s(w1, stall);
        if_s.in_valid = 1'b0;
        for (int t = 0; t < 100 && busy_s; t++) @(negedge clk);
        @(negedge clk);
        check("s_pass_end_busy", 64'(busy_s), 64'd0);
        check("s_done_pulses", 64'(n_done_s - d0), 64'd1);
        check("s_words_consumed", 64'(n_hs_s - h0), 64'd2);
        check("s_write_count", 64'(n_wr_s - r0), 64'd12);
        check("s_queue_empty", 64'(exp_q_s.size()), 64'd0);
        for (int l = 0; l < 3; l++) check("s_lut_contents", 64'(mem_s[l]), 64'(exp_mem_s[l]));
    endtask

    task automatic run_pass_d();
        int d0, h0, r0;
        bit ok;
        logic [31:0] w;
        pos_d = 0;
        exp_q_d.delete();
        d0 = n_done_d; h0 = n_hs_d; r0 = n_wr_d;
        @(posedge clk); #1; start_d = 1'b1;
        @(posedge clk); #1; start_d = 1'b0;
        for (int k = 0; k < 16; k++) begin
            w = $urandom;
            if_d.in_data  = w;
            if_d.in_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                if (if_d.in_ready) ok = 1'b1;
            end
            if (!ok) begin
                fail_now("d_ready_timeout");
                break;
            end
            push_d(w);
            @(posedge clk); #1;
        end
        if_d.in_valid = 1'b0;
        for (int t = 0; t < 200 && busy_d; t++) @(negedge clk);
        @(negedge clk);
        check("d_pass_end_busy", 64'(busy_d), 64'd0);
        check("d_done_pulses", 64'(n_done_d - d0), 64'd1);
        check("d_words_consumed", 64'(n_hs_d - h0), 64'd16);
        check("d_write_count", 64'(n_wr_d - r0), 64'd512);
        check("d_queue_empty", 64'(exp_q_d.size()), 64'd0);
        for (int l = 0; l < 8; l++) check("d_lut_contents", mem_d[l], exp_mem_d[l]);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d0;
        bit ok;
        if_s.in_data = '0; if_s.in_valid = 1'b0;
        if_d.in_data = '0; if_d.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs_s", 64'({if_s.in_ready, addr_s, d_s, we_s, busy_s, done_s}), 64'd0);
        check("rst_outputs_d", 64'({if_d.in_ready, addr_d, d_d, we_d, busy_d, done_d}), 64'd0);
        reset = 1'b0;

        // Known pattern, source keeps valid asserted.
        run_pass_s(8'hA5, 8'h3C, 0, 1'b0);
        check("s_known_lut0", 64'(mem_s[0]), 64'h5);
        check("s_known_lut1", 64'(mem_s[1]), 64'hA);
        check("s_known_lut2", 64'(mem_s[2]), 64'hC);

        // Same pattern with the source stalling in every LOAD.
        for (int l = 0; l < 3; l++) mem_s[l] = 4'h0;
        run_pass_s(8'hA5, 8'h3C, 5, 1'b0);
        check("s_stall_lut0", 64'(mem_s[0]), 64'h5);
        check("s_stall_lut1", 64'(mem_s[1]), 64'hA);
        check("s_stall_lut2", 64'(mem_s[2]), 64'hC);

        for (int k = 0; k < 4; k++)
            run_pass_s(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);

        // start while busy must not disturb the pass.
        run_pass_s(8'($urandom), 8'($urandom), 0, 1'b1);

        // abort in the LOAD cycle that offers a word.
        pos_s = 0;
        exp_q_s.delete();
        d0 = n_done_s;
        start_pulse_s();
        wait_ready_s(ok);
        @(posedge clk); #1;
        if_s.in_data  = 8'($urandom);
        if_s.in_valid = 1'b1;
        abort_s       = 1'b1;
        @(posedge clk); #1;
        abort_s       = 1'b0;
        if_s.in_valid = 1'b0;
        check("abort_busy", 64'(busy_s), 64'd0);
        check("abort_ready", 64'(if_s.in_ready), 64'd0);
        repeat (5) @(negedge clk);
        check("abort_no_done", 64'(n_done_s - d0), 64'd0);

        // reset during the 3rd write of the second word.
        pos_s = 0;
        exp_q_s.delete();
        start_pulse_s();
        feed_s(8'($urandom), 0);
        feed_s(8'($urandom), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_we", 64'(we_s), 64'd4);
        check("pre_reset_addr", 64'(addr_s), 64'd2);
        reset = 1'b1;
        #1;
        check("mid_reset_outputs", 64'({if_s.in_ready, addr_s, d_s, we_s, busy_s, done_s}), 64'd0);
        if_s.in_valid = 1'b0;
        exp_q_s.delete();
        d0 = n_done_s;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_busy", 64'(busy_s), 64'd0);
        check("post_reset_no_done", 64'(n_done_s - d0), 64'd0);
        run_pass_s(8'($urandom), 8'($urandom), 0, 1'b0);

        // Default-sized bank with random data.
        run_pass_d();
        run_pass_d();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
